// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial A - B - Bin, LSB first, with start/busy/done handshake.
// Defining SERIAL_SUB_OVF_EN adds o_Ovf, the signed overflow of the completed result.
module serial_subtractor #(
   parameter int N = 4
) (
   input  logic         i_Clk,
   input  logic         i_Rst,
   input  logic         i_Start,
   input  logic [N-1:0] i_A,
   input  logic [N-1:0] i_B,
   input  logic         i_Bin,
   output logic         o_Busy,
   output logic         o_Done,
   output logic [N-1:0] o_Diff,
   output logic         o_Bout
`ifdef SERIAL_SUB_OVF_EN
   ,output logic        o_Ovf
`endif
);
   localparam int CW = (N > 2) ? $clog2(N) : 1;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state_q, state_d;
   logic [N-1:0] a_sr_q, a_sr_d, b_sr_q, b_sr_d, r_sr_q, r_sr_d, diff_q, diff_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic br_q, br_d, bout_q, bout_d;
   logic a, b, d, br_n, accept, run, last;
`ifdef SERIAL_SUB_OVF_EN
   logic ovf_q, ovf_d;
`endif
   always_ff @(posedge i_Clk) begin
      if (i_Rst) state_q <= IDLE;
      else       state_q <= state_d;
   end
   always_comb begin
      accept  = i_Start && (state_q != RUN);
      run     = (state_q == RUN);
      last    = run && (cnt_q == CW'(N-1));
      state_d = accept ? RUN : last ? DONE : run ? RUN : IDLE;
   end
   always_comb begin
      o_Busy = (state_q == RUN);
      o_Done = (state_q == DONE);
      o_Diff = diff_q;
      o_Bout = bout_q;
`ifdef SERIAL_SUB_OVF_EN
      o_Ovf  = ovf_q;
`endif
   end
   // One full-subtractor cell shared across all bit positions.
   always_comb begin
      a      = a_sr_q[0];
      b      = b_sr_q[0];
      d      = a ^ b ^ br_q;
      br_n   = (~a & b) | (~a & br_q) | (b & br_q);
      a_sr_d = accept ? i_A : run ? {1'b0, a_sr_q[N-1:1]} : a_sr_q;
      b_sr_d = accept ? i_B : run ? {1'b0, b_sr_q[N-1:1]} : b_sr_q;
      r_sr_d = run ? {d, r_sr_q[N-1:1]} : r_sr_q;
      br_d   = accept ? i_Bin : run ? br_n : br_q;
      cnt_d  = accept ? '0 : run ? cnt_q + CW'(1) : cnt_q;
      diff_d = last ? {d, r_sr_q[N-1:1]} : diff_q;
      bout_d = last ? br_n : bout_q;
`ifdef SERIAL_SUB_OVF_EN
      ovf_d  = last ? (br_q ^ br_n) : ovf_q;
`endif
   end
   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         a_sr_q <= '0;
         b_sr_q <= '0;
         r_sr_q <= '0;
         br_q   <= 1'b0;
         cnt_q  <= '0;
         diff_q <= '0;
         bout_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
         ovf_q  <= 1'b0;
`endif
      end else begin
         a_sr_q <= a_sr_d;
         b_sr_q <= b_sr_d;
         r_sr_q <= r_sr_d;
         br_q   <= br_d;
         cnt_q  <= cnt_d;
         diff_q <= diff_d;
         bout_q <= bout_d;
`ifdef SERIAL_SUB_OVF_EN
         ovf_q  <= ovf_d;
`endif
      end
   end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: randomized and directed checks of serial_subtractor against an arithmetic model.
module tb_serial_subtractor;
   localparam int N = 4;
   logic clk = 1'b0;
   logic rst, start, bin_i, busy, done, bout;
   logic [N-1:0] a_i, b_i, diff;
   logic [N-1:0] prev_diff = '0;
   logic prev_bout = 1'b0;
   int n_chk = 0;
   int n_fail = 0;
`ifdef SERIAL_SUB_OVF_EN
   logic ovf;
   logic prev_ovf = 1'b0;
`endif
   serial_subtractor #(.N(N)) dut (
      .i_Clk(clk), .i_Rst(rst), .i_Start(start), .i_A(a_i), .i_B(b_i), .i_Bin(bin_i),
      .o_Busy(busy), .o_Done(done), .o_Diff(diff), .o_Bout(bout)
`ifdef SERIAL_SUB_OVF_EN
      , .o_Ovf(ovf)
`endif
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask
   task automatic chk_held();
      chk("diff_hold", 32'(diff), 32'(prev_diff));
      chk("bout_hold", 32'(bout), 32'(prev_bout));
`ifdef SERIAL_SUB_OVF_EN
      chk("ovf_hold", 32'(ovf), 32'(prev_ovf));
`endif
   endtask
   // Starts one operation; poke pulses a competing start mid-run, b2b leaves the next start to land in DONE.
   task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic bin,
                         input bit poke, input bit b2b);
      int r, sr;
      r  = int'(a) - int'(b) - int'(bin);
      sr = int'($signed(a)) - int'($signed(b)) - int'(bin);
      a_i = a;
      b_i = b;
      bin_i = bin;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      a_i = N'($urandom);
      b_i = N'($urandom);
      bin_i = 1'($urandom);
      for (int k = 0; k < N; k++) begin
         chk("busy_run", 32'(busy), 32'd1);
         chk("done_run", 32'(done), 32'd0);
         chk_held();
         start = poke && (k == 1);
         if (poke && k == 1) begin
            a_i = 1;
            b_i = 1;
         end
         @(posedge clk); #1;
      end
      start = 1'b0;
      chk("done", 32'(done), 32'd1);
      chk("busy_done", 32'(busy), 32'd0);
      chk("diff", 32'(diff), 32'(r & ((1 << N) - 1)));
      chk("bout", 32'(bout), 32'(r < 0));
      prev_diff = N'(r & ((1 << N) - 1));
      prev_bout = (r < 0);
`ifdef SERIAL_SUB_OVF_EN
      chk("ovf", 32'(ovf), 32'((sr < -(1 << (N-1))) || (sr > (1 << (N-1)) - 1)));
      prev_ovf = (sr < -(1 << (N-1))) || (sr > (1 << (N-1)) - 1);
`else
      if (sr > (1 << N)) $display("unexpected model value %0d", sr);
`endif
      if (!b2b) begin
         @(posedge clk); #1;
         chk("done_pulse", 32'(done), 32'd0);
         chk("busy_idle", 32'(busy), 32'd0);
         chk_held();
      end
   endtask
   initial begin
      rst = 1'b1;
      start = 1'b0;
      a_i = '0;
      b_i = '0;
      bin_i = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk_held();
      run_op(4'd9, 4'd3, 1'b0, 1'b0, 1'b0);
      run_op(4'd3, 4'd9, 1'b0, 1'b0, 1'b0);
      run_op(4'd0, 4'd0, 1'b1, 1'b0, 1'b0);
      run_op(4'd9, 4'd3, 1'b0, 1'b1, 1'b0);
      run_op(4'd9, 4'd3, 1'b0, 1'b0, 1'b1);
      run_op(4'd7, 4'd7, 1'b0, 1'b0, 1'b0);
      run_op(4'h8, 4'd1, 1'b0, 1'b0, 1'b0);
      run_op(4'd5, 4'd2, 1'b0, 1'b0, 1'b0);
      run_op(4'd9, 4'd3, 1'b0, 1'b0, 1'b0);
      // Abort an operation after two bit-steps.
      a_i = 4'd2;
      b_i = 4'd5;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      prev_diff = '0;
      prev_bout = 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      prev_ovf = 1'b0;
`endif
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      chk_held();
      for (int k = 0; k < N + 2; k++) begin
         @(posedge clk); #1;
         chk("abort_no_done", 32'(done), 32'd0);
      end
      run_op(4'd9, 4'd3, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 40; i++)
         run_op(N'($urandom), N'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 1) == 1));
      @(posedge clk); #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial N-bit subtractor: computes i_A - i_B - i_Bin one bit per clock, LSB first, with a registered borrow chain.
- It is the inverse-operation counterpart of the combinational carry-chain adder. It trades latency for one full-subtractor cell plus shift registers.
- Used where area matters more than throughput: counters, address decrement, comparator back-ends.
- Start/busy/done handshake toward the requesting logic.

Parameters:
- N, 4, operand and result width in bits (N >= 2).

Ports:
- i_Clk  input  1  system clock, all state on rising edge
- i_Rst  input  1  synchronous, active-high reset
- i_Start  input  1  request; sampled only when not busy
- i_A  input  N  minuend; captured on accepted start
- i_B  input  N  subtrahend; captured on accepted start
- i_Bin  input  1  borrow-in; captured on accepted start
- o_Busy  output  1  high while in RUN
- o_Done  output  1  one-cycle pulse; result valid
- o_Diff  output  N  registered difference, held until next completion
- o_Bout  output  1  registered final borrow-out (1 = A < B + Bin unsigned)

Behaviour:
- One clock, i_Clk. Reset i_Rst is synchronous and active-high.
- Reset (synchronous, any state, including mid-RUN):
  - state = IDLE.
  - o_Busy, o_Done, o_Diff, o_Bout all 0.
  - Internal shift registers, borrow register and bit counter cleared.
  - No o_Done is produced for the aborted operation.
- States:
  - IDLE: waiting.
  - RUN: N bit-steps.
  - DONE: one cycle, o_Done = 1.
- Start acceptance:
  - i_Start is accepted on an edge where state is IDLE or DONE.
  - On acceptance: latch i_A and i_B into shift registers, borrow register = i_Bin, counter = 0, go to RUN.
  - i_Start while in RUN is ignored, with no effect on the operation or the operand latches.
  - i_A, i_B and i_Bin may change freely after acceptance.
- RUN step (each edge):
  - a = A_sr[0], b = B_sr[0], br = borrow register.
  - d = a ^ b ^ br.
  - br_next = (~a & b) | (~a & br) | (b & br).
  - Shift d into the result shift register from the MSB side; shift A_sr and B_sr right; borrow register = br_next; counter++.
- Completion:
  - On the RUN edge processing bit N-1, load o_Diff with the completed result word and o_Bout = br_next, then go to DONE.
  - o_Diff and o_Bout change only on this edge (or reset). They stay stable throughout the next RUN.
- Timing:
  - o_Busy = (state == RUN), combinationally decoded from the state register.
  - o_Done = (state == DONE).
  - Latency: start accepted at edge 0 → o_Done high in the cycle after edge N.
  - Back-to-back starts (start held, or asserted in DONE) give one result every N+1 cycles.
- DONE transitions:
  - DONE → RUN if i_Start on that edge.
  - DONE → IDLE otherwise.
- Arithmetic: result is modulo 2^N. Wrap-around is reported via o_Bout only.

Optional Feature:
- Macro: SERIAL_SUB_OVF_EN.
- When defined:
  - Extra port o_Ovf, output, 1 bit: signed two's-complement overflow of A - B - Bin.
  - o_Ovf = borrow into bit N-1 XOR borrow out of bit N-1, captured in a register on the completion edge alongside o_Diff.
  - Reset to 0; held until next completion.
- When undefined: port and logic are absent; all other behaviour is identical.

Test Plan (N = 4):
- Basic subtraction: reset, then start with A=9, B=3, Bin=0 → o_Busy high 4 cycles, o_Done pulse in cycle after edge 4, o_Diff=6, o_Bout=0.
- Wrap-around and borrow-in:
  - A=3, B=9, Bin=0 → o_Diff=4'hA, o_Bout=1.
  - A=0, B=0, Bin=1 → o_Diff=4'hF, o_Bout=1.
- Start during RUN: start A=9,B=3; during RUN pulse start with A=1,B=1 → ignored, result 6, exactly one o_Done.
- Back-to-back: start A=9,B=3, hold i_Start with A=7,B=7 on the DONE edge:
  - o_Diff=6 in the first DONE cycle.
  - Second operation runs immediately; o_Diff stays 6 until o_Diff=0, o_Bout=0 at the next o_Done, 5 cycles after the first.
- Reset mid-operation: assert i_Rst at RUN bit 2 → next cycle all outputs 0, state IDLE, no o_Done; a fresh start then completes normally.
- With SERIAL_SUB_OVF_EN:
  - A=4'h8, B=1, Bin=0 → o_Diff=7, o_Bout=0, o_Ovf=1.
  - A=5, B=2 → o_Ovf=0.
